// File: rtl/rr_arbiter8_3.sv
// rtl/rr_arbiter8_3.sv - 8-requester round-robin arbiter with hold limit, one-hot and encoded grant
// Optional held-grant extension (lock port) enabled by defining RR_ARB_LOCK_EN.
`timescale 1ns/1ps

module rr_arbiter8_3 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
`ifdef RR_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [7:0] gnt,
    output logic [2:0] A,
    output logic       valid
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] a_q, a_d;
    logic       valid_q, valid_d;

    logic       lock_s;
    logic       at_limit;
    logic       rel;
    logic       do_search;
    logic [2:0] search_ptr;
    logic [3:0] hit;

`ifdef RR_ARB_LOCK_EN
    assign lock_s = lock;
`else
    assign lock_s = 1'b0;
`endif

    // Returns {found, index}; offsets scanned high to low so the nearest one to p wins.
    function automatic logic [3:0] rr_search(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] k;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            k = p + 3'(i);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    assign at_limit = (hold_q == HOLD_LAST);
    assign hit      = rr_search(req, search_ptr);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        gnt_d      = gnt_q;
        a_d        = a_q;
        valid_d    = valid_q;
        rel        = 1'b0;
        do_search  = 1'b0;
        search_ptr = ptr_q;

        case (state_q)
            IDLE: begin
                do_search = en && (req != 8'h00);
            end
            BUSY: begin
                // Saturation only matters while locked; otherwise at_limit always releases.
                hold_d = at_limit ? hold_q : hold_q + 8'd1;
                if (!req[a_q] || (at_limit && !lock_s) || !en) begin
                    rel        = 1'b1;
                    ptr_d      = a_q + 3'd1;
                    search_ptr = a_q + 3'd1;
                    do_search  = en;
                end
            end
            default: ;
        endcase

        if (do_search && hit[3]) begin
            gnt_d   = 8'd1 << hit[2:0];
            a_d     = hit[2:0];
            valid_d = 1'b1;
            hold_d  = 8'd0;
            state_d = BUSY;
        end else if (rel || state_q == IDLE) begin
            gnt_d   = 8'h00;
            a_d     = 3'd0;
            valid_d = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            hold_q  <= 8'd0;
            gnt_q   <= 8'h00;
            a_q     <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            valid_q <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign A     = a_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8_3.sv
// tb/tb_rr_arbiter8_3.sv - scoreboard bench for rr_arbiter8_3 (lock scenario when RR_ARB_LOCK_EN is defined)
`timescale 1ns/1ps

module tb_rr_arbiter8_3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
`ifdef RR_ARB_LOCK_EN
    logic       lock;
`endif
    logic [7:0] gnt;
    logic [2:0] A;
    logic       valid;

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] sb[$];
    logic [11:0] obs;
    logic [11:0] exp_v;

    always #5 clk = ~clk;

    rr_arbiter8_3 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .req   (req),
`ifdef RR_ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .A     (A),
        .valid (valid)
    );

    function automatic logic [11:0] gexp(input int idx);
        return {1'b1, 3'(idx), 8'(8'd1 << idx)};
    endfunction

    task automatic drive(input logic [7:0] r, input logic e);
        @(negedge clk);
        req = r;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        en  = 1'b0;
`ifdef RR_ARB_LOCK_EN
        lock = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        en  = 1'b1;
        #1;
        checks++;
        if ({valid, A, gnt} !== 12'h000) begin
            failures++;
            $display("FAIL reset_state: got v=%b A=%0d gnt=%h, want all zero", valid, A, gnt);
        end
        do_reset();
    endtask

    task automatic test_pair();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            sb.push_back(gexp(((k / 4) % 2) ? 7 : 0));
            drive(8'h81, 1'b1);
            obs = {valid, A, gnt};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL pair_81 cyc%0d: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 36; k++) begin
            sb.push_back(gexp((k / 4) % 8));
            drive(8'hFF, 1'b1);
            obs = {valid, A, gnt};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL wrap_ff cyc%0d: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_drop();
        logic [7:0] r_tab[4] = '{8'h08, 8'h08, 8'h00, 8'h28};
        logic [11:0] e_tab[4];
        e_tab = '{gexp(3), gexp(3), 12'h000, gexp(5)};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            sb.push_back(e_tab[k]);
            drive(r_tab[k], 1'b1);
            obs = {valid, A, gnt};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL drop_req3 cyc%0d: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_enable();
        logic [7:0] r_tab[8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic       e_tab[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [11:0] x_tab[8];
        x_tab = '{12'h000, 12'h000, 12'h000, gexp(0), gexp(0), 12'h000, gexp(1), 12'h000};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            sb.push_back(x_tab[k]);
            drive(r_tab[k], e_tab[k]);
            obs = {valid, A, gnt};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL enable cyc%0d: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_drop_at_timeout();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            sb.push_back((k < 4) ? gexp(0) : gexp(1));
            drive((k < 4) ? 8'h83 : 8'h82, 1'b1);
            obs = {valid, A, gnt};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL drop_timeout cyc%0d: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            sb.push_back(gexp((k < 4) ? 0 : 1));
            drive(8'hFF, 1'b1);
            obs = {valid, A, gnt};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL async_pre cyc%0d: got %h want %h", k, obs, exp_v);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({valid, A, gnt} !== 12'h000) begin
            failures++;
            $display("FAIL async_clear: got v=%b A=%0d gnt=%h, want all zero", valid, A, gnt);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(gexp(0));
        drive(8'hFF, 1'b1);
        obs = {valid, A, gnt};
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL async_ptr: got %h want %h", obs, exp_v);
        end
    endtask

`ifdef RR_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        lock = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k == 10) lock = 1'b0;
            sb.push_back((k < 10) ? gexp(2) : gexp(5));
            drive(8'h24, 1'b1);
            obs = {valid, A, gnt};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL lock cyc%0d: got %h want %h", k, obs, exp_v);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pair();
        test_wrap();
        test_drop();
        test_enable();
        test_drop_at_timeout();
        test_async_reset();
`ifdef RR_ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
